seg7_scan_driver: RTL and testbench

- Downstream display stage for the Pipeline5 core on the FPGA board.
- Takes a 16-bit value published by the core and time-multiplexes it onto four common-segment 7-segment digits as hex.
- Drives `leds` (segments) and `enable` (digit select, active-high one-hot); the board wrapper inverts `enable` for the pads.
- Replaces direct combinational drive of the display with a refresh counter and tear-free frame latching.

---
 rtl/seg7_scan_driver.sv | 105 ++++++++++
 tb/tb_seg7_scan_driver.sv | 120 ++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed four-digit hex display driver with a refresh counter and
// tear-free frame latching; every output is registered.
module seg7_scan_driver #(
    parameter int unsigned CLK_DIV        = 100000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        value_valid,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    output logic [7:0]  leds,
    output logic [3:0]  enable,
    output logic        frame_done
);

    localparam int unsigned    CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  CntMax   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  CntOne   = CW'(1);
    localparam logic [7:0]     LedsIdle = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic [7:0]    leds_q, leds_d;
    logic [3:0]    enable_q, enable_d;
    logic          frame_done_q, frame_done_d;

    logic          wrap;
    logic          tick;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            shadow_q     <= 16'h0000;
            disp_q       <= 16'h0000;
            leds_q       <= LedsIdle;
            enable_q     <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            leds_q       <= leds_d;
            enable_q     <= enable_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state: scan position and frame latching
    always_comb begin
        wrap         = (cnt_q == CntMax);
        tick         = wrap && (digit_q == 2'd3);
        cnt_d        = wrap ? '0 : cnt_q + CntOne;
        digit_d      = wrap ? digit_q + 2'd1 : digit_q;
        shadow_d     = value_valid ? value : shadow_q;
        // A strobe on the tick cycle passes straight into the next frame.
        disp_d       = tick ? shadow_d : disp_q;
        frame_done_d = tick;
    end

    // Output decode from the current digit and latched frame
    always_comb begin
        nib      = disp_q[{digit_q, 2'b00} +: 4];
        blank    = blank_mask[digit_q];
        enable_d = blank ? 4'b0000 : (4'b0001 << digit_q);
        leds_d   = {dp_mask[digit_q] & ~blank, blank ? 7'h00 : hex_seg(nib)};
        leds_d   = leds_d ^ {8{SEG_ACTIVE_LOW}};
    end

    assign leds       = leds_q;
    assign enable     = enable_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with CLK_DIV=4; a second instance
// with SEG_ACTIVE_LOW=1 shares the stimulus.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        value_valid;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic [7:0]  leds, leds_al;
    logic [3:0]  enable, enable_al;
    logic        frame_done, frame_done_al;

    int checks   = 0;
    int failures = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg7_scan_driver #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .leds        (leds),
        .enable      (enable),
        .frame_done  (frame_done)
    );

    seg7_scan_driver #(.CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut_al (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .value_valid (value_valid),
        .dp_mask     (dp_mask),
        .blank_mask  (blank_mask),
        .leds        (leds_al),
        .enable      (enable_al),
        .frame_done  (frame_done_al)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs n cycles of a frame that shows exp_disp; optionally strobes sv
    // after sample strobe_at so it lands on the following edge.
    task automatic run_frame(input string tag, input logic [15:0] exp_disp,
                             input logic [3:0] dp, input logic [3:0] blank,
                             input int n, input int strobe_at, input logic [15:0] sv);
        int d;
        logic [3:0] nib, exp_en;
        logic [7:0] exp_leds;
        dp_mask    = dp;
        blank_mask = blank;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            d        = i / 4;
            nib      = exp_disp[d*4 +: 4];
            exp_en   = blank[d] ? 4'b0000 : (4'b0001 << d);
            exp_leds = blank[d] ? 8'h00 : {dp[d], hex_tab[nib]};
            chk($sformatf("%s en i=%0d", tag, i), {4'h0, enable}, {4'h0, exp_en});
            chk($sformatf("%s leds i=%0d", tag, i), leds, exp_leds);
            chk($sformatf("%s fd i=%0d", tag, i), {7'h0, frame_done}, {7'h0, i == 15});
            chk($sformatf("%s leds_al i=%0d", tag, i), leds_al, ~exp_leds);
            chk($sformatf("%s en_al i=%0d", tag, i), {4'h0, enable_al}, {4'h0, exp_en});
            value_valid = (i == strobe_at);
            if (i == strobe_at) value = sv;
        end
    endtask

    initial begin
        rst         = 1'b0;
        value       = 16'h0000;
        value_valid = 1'b0;
        dp_mask     = 4'b0000;
        blank_mask  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst leds", leds, 8'h00);
        chk("rst en", {4'h0, enable}, 8'h00);
        chk("rst fd", {7'h0, frame_done}, 8'h00);
        chk("rst leds_al", leds_al, 8'hFF);
        rst = 1'b1;

        // Idle frame; strobe 12AF lands just after the tick, so it waits a frame.
        run_frame("fA", 16'h0000, 4'b0000, 4'b0000, 16, 15, 16'h12AF);
        run_frame("fB", 16'h0000, 4'b0000, 4'b0000, 16, -1, 16'h0000);
        // Strobe 0000 while digit1 is lit: current frame unaffected.
        run_frame("fC", 16'h12AF, 4'b0000, 4'b0000, 16, 5, 16'h0000);
        // Strobe on the tick cycle itself reaches the very next frame.
        run_frame("fD", 16'h0000, 4'b0000, 4'b0000, 16, 14, 16'h12AF);
        run_frame("fE", 16'h12AF, 4'b0100, 4'b1000, 16, -1, 16'h0000);
        // Abort mid-frame while digit2 is lit.
        run_frame("fF", 16'h12AF, 4'b0000, 4'b0000, 9, -1, 16'h0000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid rst leds", leds, 8'h00);
        chk("mid rst en", {4'h0, enable}, 8'h00);
        chk("mid rst fd", {7'h0, frame_done}, 8'h00);
        chk("mid rst leds_al", leds_al, 8'hFF);
        rst = 1'b1;
        run_frame("fG", 16'h0000, 4'b0000, 4'b0000, 16, -1, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
